// File: rtl/pkt_arb_pkg.sv
// -----------------------------------------------------------------------------
// pkt_arb_pkg
// Shared defaults and types for the packet round-robin arbiter.
//   NUM_PORTS_DEF  : default requester count (2..8)
//   DATA_WIDTH_DEF : default TDATA width
//   CNT_WIDTH_DEF  : default per-port packet counter width
//   arb_state_t    : arbiter FSM state {IDLE, LOCKED}
//   onehot_to_idx  : encodes a one-hot vector (up to 8 bits) to its index
// -----------------------------------------------------------------------------
package pkt_arb_pkg;

    localparam int NUM_PORTS_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 512;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // OR-reduction encoder; the input is assumed one-hot or zero.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requester at or above
// the pointer, wrapping from NUM_PORTS-1 back to 0.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this search
//   o_gnt   : one-hot winner (all zero when nobody requests)
//   o_valid : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic                 o_valid
);

    logic [PTR_W-1:0] w_idx;
    logic             w_take;

    // Walk the ports in priority order; the first hit claims the grant.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        w_take  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx        = PTR_W'((int'(i_ptr) + k) % NUM_PORTS);
            w_take       = i_req[w_idx] & ~o_valid;
            o_gnt[w_idx] = w_take;
            o_valid      = o_valid | w_take;
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_rr_arbiter
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream requesters into one
// registered egress stream.
//   clk, rst          : clock, asynchronous active-high reset
//   s_tvalid/s_tready : per-port handshake
//   s_tdata           : port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tlast, s_tuser  : per-port end-of-packet, metadata-beat flag
//   m_t*              : merged egress stream (one register stage)
//   grant             : one-hot current owner, zero when idle
//   proto_err         : sticky, packet started with a payload beat
//   pkt_cnt           : packets forwarded per port, port i at [i*CNT_WIDTH +: CNT_WIDTH]
// -----------------------------------------------------------------------------
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS-1:0]            s_tuser,
    output logic                            m_tvalid,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast,
    output logic                            m_tuser,
    input  logic                            m_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            proto_err,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t                           r_state;
    arb_state_t                           w_next_state;
    logic [NUM_PORTS-1:0]                 r_grant;
    logic [PTR_W-1:0]                     r_grant_idx;
    logic [PTR_W-1:0]                     r_rr_ptr;
    logic                                 r_first;
    logic                                 r_m_valid;
    logic [DATA_WIDTH-1:0]                r_m_data;
    logic                                 r_m_last;
    logic                                 r_m_user;
    logic [NUM_PORTS-1:0]                 r_proto_err;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  r_pkt_cnt;

    logic [NUM_PORTS-1:0]  w_win_gnt;
    logic                  w_win_valid;
    logic [PTR_W-1:0]      w_win_idx;
    logic                  w_egress_free;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic                  w_sel_user;
    logic                  w_accept;
    logic                  w_done;
    logic [PTR_W-1:0]      w_ptr_next;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .i_req   (s_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_win_gnt),
        .o_valid (w_win_valid)
    );

    assign w_win_idx     = PTR_W'(onehot_to_idx(8'(w_win_gnt)));
    assign w_egress_free = ~r_m_valid | m_tready;
    assign w_sel_valid   = s_tvalid[r_grant_idx];
    assign w_sel_data    = s_tdata[int'(r_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_last    = s_tlast[r_grant_idx];
    assign w_sel_user    = s_tuser[r_grant_idx];
    assign w_accept      = (r_state == LOCKED) & w_egress_free & w_sel_valid;
    assign w_done        = w_accept & w_sel_last;
    assign w_ptr_next    = (r_grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_grant_idx + PTR_W'(1);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: lock onto any request, release on the accepted TLAST beat.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_next_state = LOCKED;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOCKED: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = LOCKED;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only if the egress register can take a beat.
    always_comb begin
        s_tready = '0;
        if ((r_state == LOCKED) && w_egress_free) begin
            s_tready = r_grant;
        end else begin
            s_tready = '0;
        end
    end

    // Grant ownership and round-robin pointer; the IDLE cycle is the arbitration bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_first     <= 1'b0;
        end else if ((r_state == IDLE) && w_win_valid) begin
            r_grant     <= w_win_gnt;
            r_grant_idx <= w_win_idx;
            r_first     <= 1'b1;
        end else if (w_done) begin
            r_grant     <= '0;
            r_rr_ptr    <= w_ptr_next;
            r_first     <= 1'b0;
        end else if (w_accept) begin
            r_first     <= 1'b0;
        end
    end

    // Egress register: load on accept, drop valid once drained with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_m_last  <= w_sel_last;
            r_m_user  <= w_sel_user;
        end else if (w_egress_free) begin
            r_m_valid <= 1'b0;
        end
    end

    // Sticky protocol error on a payload-first packet, and per-port packet counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            if (w_accept && r_first && !w_sel_user) begin
                r_proto_err[r_grant_idx] <= 1'b1;
            end
            if (w_done) begin
                r_pkt_cnt[r_grant_idx] <= r_pkt_cnt[r_grant_idx] + CNT_WIDTH'(1);
            end
        end
    end

    assign grant     = r_grant;
    assign m_tvalid  = r_m_valid;
    assign m_tdata   = r_m_data;
    assign m_tlast   = r_m_last;
    assign m_tuser   = r_m_user;
    assign proto_err = r_proto_err;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, 4, number of packet+meta AXI-Stream requesters (2..8).
REQ-002 Parameter DATA_WIDTH, 512, TDATA width of every port.
REQ-003 Parameter CNT_WIDTH, 16, width of each per-port packet counter.
REQ-004 Port clk  in  1  single clock; all logic rising-edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port s_tvalid  in  NUM_PORTS  per-requester beat valid.
REQ-007 Port s_tready  out  NUM_PORTS  per-requester beat accept.
REQ-008 Port s_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port s_tlast  in  NUM_PORTS  per-requester end-of-packet.
REQ-010 Port s_tuser  in  NUM_PORTS  1 = metadata beat, 0 = payload beat.
REQ-011 Port m_tvalid, m_tdata, m_tlast, m_tuser  out  1/DATA_WIDTH/1/1  merged egress stream.
REQ-012 Port m_tready  in  1  egress accept.
REQ-013 Port grant  out  NUM_PORTS  one-hot owner of egress; all-zero when idle.
REQ-014 Port proto_err  out  NUM_PORTS  sticky: port started a packet with s_tuser=0.
REQ-015 Port pkt_cnt  out  NUM_PORTS*CNT_WIDTH  packets forwarded per port.

Function
REQ-016 FSM states IDLE and LOCKED; IDLE->LOCKED when any s_tvalid=1; LOCKED->IDLE on the cycle the granted port's beat with s_tlast=1 is accepted.
REQ-017 In IDLE, grant goes next cycle to the first port with s_tvalid=1 searching upward from rr_ptr, wrapping NUM_PORTS-1 -> 0.
REQ-018 rr_ptr resets to 0; on LOCKED->IDLE it becomes (granted index + 1) mod NUM_PORTS.
REQ-019 Grant is packet-atomic: held through all beats until TLAST regardless of other requests or granted s_tvalid gaps; no timeout.
REQ-020 s_tready[i] = LOCKED && grant[i] && (!m_tvalid || m_tready); all other ports see 0.
REQ-021 Egress is one register stage: an accepted beat appears on m_* the next cycle, data/last/user copied unmodified.
REQ-022 m_tvalid clears when the register is free (!m_tvalid || m_tready) and no beat is accepted that cycle.
REQ-023 While m_tvalid=1 and m_tready=0, m_tdata/m_tlast/m_tuser hold stable.
REQ-024 Single-beat packet (first beat has s_tlast=1) is legal: forwarded, then IDLE.
REQ-025 Arbitration bubble: exactly one idle cycle between packets (IDLE state), never zero.
REQ-026 First accepted beat of a packet with s_tuser=0 sets proto_err[i]; beat is still forwarded; only reset clears.
REQ-027 pkt_cnt[i] increments by 1 when port i's TLAST beat is accepted; wraps 2^CNT_WIDTH-1 -> 0.
REQ-028 Ports with s_tvalid=0 in IDLE are skipped; if none valid, stay IDLE, rr_ptr unchanged.

Reset
REQ-029 On rst: state=IDLE, rr_ptr=0, grant=0, s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, proto_err=0, pkt_cnt=0.
REQ-030 Reset mid-packet drops the in-flight packet silently; after release arbitration restarts from port 0.

Structure
REQ-031 Package pkt_arb_pkg holds NUM_PORTS/DATA_WIDTH/CNT_WIDTH defaults and the arb_state_t enum {IDLE, LOCKED}.
REQ-032 Sub-module rr_pick: combinational request vector + rr_ptr -> one-hot winner and valid; instanced once.

Verification
REQ-033 Ports 0,1,2 each send a 4-beat packet (meta + 3 payload) at once, m_tready=1 -> egress order 0,1,2; 12 beats; one bubble between packets; pkt_cnt = 1,1,1,0.
REQ-034 Port 1 sends 4-beat packet; port 0 raises s_tvalid after beat 1 -> port 0 gets no s_tready until port 1 TLAST accepted, then served next.
REQ-035 m_tready toggled 1,0,0,1 during packet with DATA=0xA5.. -> m_tdata stable during stall; no beat lost or duplicated; s_tready low during stall.
REQ-036 Port 3 sends single-beat packet TUSER=1, TLAST=1, then all 4 ports request -> next grant order 0,1,2,3 (rr_ptr wrapped to 0).
REQ-037 Port 2 packet starting with TUSER=0 -> proto_err=4'b0100, packet forwarded intact; assert rst mid-packet -> all outputs 0, next grant from port 0.
